// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core load/store path and an external master.
// Optional ARB_PERF_CNT_EN adds free-running stall-cycle and external-grant counters.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   output logic              cancel_data_memory,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_core_stall_cyc,
   output logic [31:0]       perf_ext_grants
`endif
);

   localparam logic [3:0] CNT_INIT   = 4'(RD_LAT - 1);
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CORE = 2'd1,
      RD_EXT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [7:0]          streak_q, streak_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;

   logic ext_win;
   logic core_win;
   logic core_done;

   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      streak_d           = streak_q;
      addr_d             = addr_q;
      ext_rdata_d        = ext_rdata_q;
      ext_win            = 1'b0;
      core_win           = 1'b0;
      core_done          = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_wdata          = '0;
      core_rdata         = '0;
      cancel_data_memory = 1'b0;
      ext_gnt            = 1'b0;
      ext_rvalid         = 1'b0;
      ext_rdata          = ext_rdata_q;

      case (state_q)
         IDLE: begin
            ext_win  = ext_req && (!core_req || (streak_q == STARVE_LIM));
            core_win = core_req && !ext_win;
            if (ext_win) begin
               mem_we             = ext_we;
               mem_addr           = ext_addr;
               mem_wdata          = ext_wdata;
               ext_gnt            = 1'b1;
               cancel_data_memory = 1'b1;
               if (!ext_we) begin
                  state_d = RD_EXT;
                  cnt_d   = CNT_INIT;
                  addr_d  = ext_addr;
               end
            end else if (core_win) begin
               mem_we    = core_we;
               mem_addr  = core_addr;
               mem_wdata = core_wdata;
               if (core_we) begin
                  core_done = 1'b1;
               end else begin
                  state_d = RD_CORE;
                  cnt_d   = CNT_INIT;
                  addr_d  = core_addr;
               end
            end
         end
         RD_CORE: begin
            mem_addr = addr_q;
            if (cnt_q == 4'd0) begin
               core_done  = 1'b1;
               core_rdata = mem_rdata;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_EXT: begin
            mem_addr           = addr_q;
            cancel_data_memory = 1'b1;
            if (cnt_q == 4'd0) begin
               ext_rvalid  = 1'b1;
               ext_rdata   = mem_rdata;
               ext_rdata_d = mem_rdata;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      core_stall = core_req && !core_done;

      // Streak only counts core grants that actually made a waiting ext master lose.
      if (!ext_req || ext_win) begin
         streak_d = 8'd0;
      end else if (core_win && (streak_q != STARVE_LIM)) begin
         streak_d = streak_q + 8'd1;
      end

      // Outputs are forced quiet while reset is held, whatever the inputs do.
      if (reset) begin
         mem_we             = 1'b0;
         mem_addr           = '0;
         mem_wdata          = '0;
         core_rdata         = '0;
         core_stall         = 1'b0;
         cancel_data_memory = 1'b0;
         ext_gnt            = 1'b0;
         ext_rvalid         = 1'b0;
         ext_rdata          = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         streak_q    <= 8'd0;
         addr_q      <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         streak_q    <= streak_d;
         addr_q      <= addr_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_gnt_q, perf_gnt_d;

   always_comb begin
      perf_stall_d = perf_stall_q + {31'd0, core_stall};
      perf_gnt_d   = perf_gnt_q + {31'd0, ext_gnt};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_q <= 32'd0;
         perf_gnt_q   <= 32'd0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_gnt_q   <= perf_gnt_d;
      end
   end

   assign perf_core_stall_cyc = perf_stall_q;
   assign perf_ext_grants     = perf_gnt_q;
`endif

endmodule
